// File: rtl/gf163_mult_arbiter.sv
// Round-robin arbiter sharing one pipelined GF(2^163) multiplier between two requesters.
// Owns the field polynomial g and sequences drain/reload; GF_ARB_PERF_EN adds issue/stall counters.
module gf163_mult_arbiter #(
    parameter int unsigned           DATA_WIDTH = 163,
    parameter int unsigned           B_WIDTH    = 176,
    parameter int unsigned           LATENCY    = 11,
    parameter logic [DATA_WIDTH-1:0] G_RESET    = DATA_WIDTH'('hC9)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [B_WIDTH-1:0]    req0_b,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [B_WIDTH-1:0]    req1_b,
    output logic                  res0_valid,
    output logic [DATA_WIDTH-1:0] res0_data,
    output logic                  res1_valid,
    output logic [DATA_WIDTH-1:0] res1_data,
    input  logic                  cfg_g_req,
    input  logic [DATA_WIDTH-1:0] cfg_g,
    output logic                  cfg_g_ack,
    output logic                  busy,
`ifdef GF_ARB_PERF_EN
    output logic [31:0]           perf_issue0,
    output logic [31:0]           perf_issue1,
    output logic [31:0]           perf_stall,
`endif
    output logic [DATA_WIDTH-1:0] mul_a,
    output logic [B_WIDTH-1:0]    mul_b,
    output logic [DATA_WIDTH-1:0] mul_g,
    input  logic [DATA_WIDTH-1:0] mul_t
);

    localparam int unsigned CNT_W = $clog2(LATENCY + 1);

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [DATA_WIDTH-1:0] g_reg;
    logic                  last_grant;
    logic [LATENCY-1:0]    tag_vld;
    logic [LATENCY-1:0]    tag_own;
    logic [CNT_W-1:0]      inflight;
    logic [CNT_W-1:0]      inflight_nxt;
    logic                  cfg_pend_c;
    logic                  grant0_c;
    logic                  grant1_c;
    logic                  issue_c;
    logic                  retire_c;
    logic                  load_c;

    // The request is still high in the ack cycle; ignore it there so issue can resume at once.
    assign cfg_pend_c = cfg_g_req & ~cfg_g_ack;
    assign retire_c   = tag_vld[LATENCY-1];
    assign issue_c    = grant0_c | grant1_c;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (cfg_pend_c) state_nxt = DRAIN;
            DRAIN:   if (inflight == '0) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // Grant, multiplier drive and load strobe
    always_comb begin
        grant0_c = 1'b0;
        grant1_c = 1'b0;
        load_c   = 1'b0;
        mul_a    = '0;
        mul_b    = '0;
        if (rst_n && state == RUN && !cfg_pend_c) begin
            if (req0_valid && (!req1_valid || last_grant)) begin
                grant0_c = 1'b1;
            end else if (req1_valid) begin
                grant1_c = 1'b1;
            end
        end
        if (state == DRAIN && inflight == '0) begin
            load_c = 1'b1;
        end
        if (grant0_c) begin
            mul_a = req0_a;
            mul_b = req0_b;
        end else if (grant1_c) begin
            mul_a = req1_a;
            mul_b = req1_b;
        end
    end

    assign req0_ready = grant0_c;
    assign req1_ready = grant1_c;
    assign mul_g      = g_reg;

    always_comb begin
        inflight_nxt = inflight;
        if (issue_c && !retire_c) begin
            inflight_nxt = inflight + CNT_W'(1);
        end else if (!issue_c && retire_c) begin
            inflight_nxt = inflight - CNT_W'(1);
        end
    end

    // Tag pipe mirrors the multiplier latency; owner bit 1 means requester 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_reg      <= G_RESET;
            last_grant <= 1'b1;
            tag_vld    <= '0;
            tag_own    <= '0;
            inflight   <= '0;
            cfg_g_ack  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            tag_vld   <= {tag_vld[LATENCY-2:0], issue_c};
            tag_own   <= {tag_own[LATENCY-2:0], grant1_c};
            inflight  <= inflight_nxt;
            cfg_g_ack <= load_c;
            busy      <= (inflight_nxt != '0) || (state_nxt != RUN);
            if (load_c) begin
                g_reg <= cfg_g;
            end
            if (issue_c) begin
                last_grant <= grant1_c;
            end
        end
    end

    assign res0_valid = tag_vld[LATENCY-1] & ~tag_own[LATENCY-1];
    assign res1_valid = tag_vld[LATENCY-1] &  tag_own[LATENCY-1];
    assign res0_data  = mul_t;
    assign res1_data  = mul_t;

`ifdef GF_ARB_PERF_EN
    logic stall_c;
    assign stall_c = (req0_valid | req1_valid) & ~issue_c;

    // Saturating performance counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issue0 <= '0;
            perf_issue1 <= '0;
            perf_stall  <= '0;
        end else begin
            if (grant0_c && perf_issue0 != '1) perf_issue0 <= perf_issue0 + 32'd1;
            if (grant1_c && perf_issue1 != '1) perf_issue1 <= perf_issue1 + 32'd1;
            if (stall_c && perf_stall != '1)   perf_stall  <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_gf163_mult_arbiter.sv
// Self-checking bench for gf163_mult_arbiter: randomized traffic against a scoreboard model,
// with a behavioural stand-in for the pipelined multiplier driving mul_t.
module tb_gf163_mult_arbiter;

    localparam int unsigned DW  = 163;
    localparam int unsigned BW  = 176;
    localparam int          LAT = 11;
    localparam logic [DW-1:0] G_RST = 163'hC9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [DW-1:0] req0_a = '0, req1_a = '0;
    logic [BW-1:0] req0_b = '0, req1_b = '0;
    logic          res0_valid, res1_valid;
    logic [DW-1:0] res0_data, res1_data;
    logic          cfg_g_req = 1'b0;
    logic [DW-1:0] cfg_g = '0;
    logic          cfg_g_ack, busy;
    logic [DW-1:0] mul_a, mul_g, mul_t;
    logic [BW-1:0] mul_b;
`ifdef GF_ARB_PERF_EN
    logic [31:0]   perf_issue0, perf_issue1, perf_stall;
`endif

    gf163_mult_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .res0_valid(res0_valid), .res0_data(res0_data),
        .res1_valid(res1_valid), .res1_data(res1_data),
        .cfg_g_req(cfg_g_req), .cfg_g(cfg_g), .cfg_g_ack(cfg_g_ack), .busy(busy),
`ifdef GF_ARB_PERF_EN
        .perf_issue0(perf_issue0), .perf_issue1(perf_issue1), .perf_stall(perf_stall),
`endif
        .mul_a(mul_a), .mul_b(mul_b), .mul_g(mul_g), .mul_t(mul_t)
    );

    always #5 clk = ~clk;

    // a*b mod (x^163 + g), Horner over the bits of b
    function automatic logic [DW-1:0] gfmul(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [DW-1:0] g);
        logic [DW-1:0] r;
        r = '0;
        for (int i = DW - 1; i >= 0; i--) begin
            r = r[DW-1] ? ((r << 1) ^ g) : (r << 1);
            if (b[i]) r = r ^ a;
        end
        return r;
    endfunction

    // Multiplier stand-in: product of the cycle-c inputs appears on mul_t in cycle c+LAT
    logic [DW-1:0] mpipe [LAT];
    always @(posedge clk) begin
        mpipe[0] <= gfmul(mul_a, mul_b[DW-1:0], mul_g);
        for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
    end
    assign mul_t = mpipe[LAT-1];

    typedef struct {
        int            issue;
        int            due;
        bit            owner;
        logic [DW-1:0] prod;
    } op_t;

    op_t           q[$];
    int            total = 0, bad = 0;
    int            cyc = 0;
    int            last_m = 1;
    int            cfg_rise = -100, load_cyc = -100, ack_cyc = -100;
    logic [DW-1:0] g_m = G_RST, g_pend = '0;
    int            p0 = 0, p1 = 0, pst = 0;

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd163();
        logic [191:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[DW-1:0];
    endfunction

    task automatic drive(input bit v0, input bit v1);
        req0_valid = v0;
        req1_valid = v1;
        req0_a = rnd163();
        req1_a = rnd163();
        req0_b = {13'b0, rnd163()};
        req1_b = {13'b0, rnd163()};
    endtask

    // One cycle: settle, predict from the model, compare, advance to the next negedge
    task automatic step();
        bit            blocked, gr0, gr1, ev0, ev1, eb;
        logic [DW-1:0] ed0, ed1, ea;
        logic [BW-1:0] eb_op;
        #1;
        if (cyc == load_cyc + 1) g_m = g_pend;
        blocked = !rst_n || (cfg_g_req && cyc != ack_cyc);
        gr0 = 1'b0;
        gr1 = 1'b0;
        if (!blocked) begin
            if (req0_valid && req1_valid) begin
                if (last_m == 1) gr0 = 1'b1; else gr1 = 1'b1;
            end else if (req0_valid) begin
                gr0 = 1'b1;
            end else if (req1_valid) begin
                gr1 = 1'b1;
            end
        end
        ea    = gr0 ? req0_a : (gr1 ? req1_a : '0);
        eb_op = gr0 ? req0_b : (gr1 ? req1_b : '0);
        chk("req0_ready", BW'(req0_ready), BW'(gr0));
        chk("req1_ready", BW'(req1_ready), BW'(gr1));
        chk("mul_a", BW'(mul_a), BW'(ea));
        chk("mul_b", mul_b, eb_op);
        chk("mul_g", BW'(mul_g), BW'(g_m));
        ev0 = 1'b0; ev1 = 1'b0; ed0 = '0; ed1 = '0;
        foreach (q[i]) begin
            if (q[i].due == cyc) begin
                if (q[i].owner) begin ev1 = 1'b1; ed1 = q[i].prod; end
                else            begin ev0 = 1'b1; ed0 = q[i].prod; end
            end
        end
        chk("res0_valid", BW'(res0_valid), BW'(ev0));
        chk("res1_valid", BW'(res1_valid), BW'(ev1));
        if (ev0) chk("res0_data", BW'(res0_data), BW'(ed0));
        if (ev1) chk("res1_data", BW'(res1_data), BW'(ed1));
        chk("cfg_g_ack", BW'(cfg_g_ack), BW'(rst_n && cyc == ack_cyc));
        eb = rst_n && cyc > cfg_rise && cyc <= load_cyc;
        foreach (q[i]) if (q[i].issue < cyc) eb = 1'b1;
        chk("busy", BW'(busy), BW'(eb));
`ifdef GF_ARB_PERF_EN
        chk("perf_issue0", BW'(perf_issue0), BW'(p0));
        chk("perf_issue1", BW'(perf_issue1), BW'(p1));
        chk("perf_stall",  BW'(perf_stall),  BW'(pst));
`endif
        for (int i = q.size() - 1; i >= 0; i--) if (q[i].due == cyc) q.delete(i);
        if (gr0 || gr1) begin
            q.push_back('{cyc, cyc + LAT, gr1, gfmul(ea, eb_op[DW-1:0], g_m)});
            last_m = gr1 ? 1 : 0;
        end
        if (rst_n) begin
            if (gr0) p0++;
            if (gr1) p1++;
            if ((req0_valid || req1_valid) && !(gr0 || gr1)) pst++;
        end
        @(negedge clk);
        cyc++;
        if (cyc == ack_cyc + 1) cfg_g_req = 1'b0;
    endtask

    task automatic idle(input int n);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic rand_traffic(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            step();
        end
    endtask

    // Raise a g reload now; the load edge follows the last outstanding retirement
    task automatic start_cfg(input logic [DW-1:0] newg);
        int last_due;
        cfg_g_req = 1'b1;
        cfg_g     = newg;
        g_pend    = newg;
        cfg_rise  = cyc;
        last_due  = cyc;
        foreach (q[i]) if (q[i].due > last_due) last_due = q[i].due;
        load_cyc = last_due + 1;
        ack_cyc  = load_cyc + 1;
    endtask

    task automatic run_cfg(input logic [DW-1:0] newg, input bit traffic);
        start_cfg(newg);
        for (int i = 0; i < 40 && cyc <= ack_cyc; i++) begin
            if (traffic) drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else         drive(1'b0, 1'b0);
            step();
        end
    endtask

    task automatic apply_reset(input int n);
        @(negedge clk);
        rst_n = 1'b0;
        q.delete();
        last_m = 1;
        g_m = G_RST;
        cfg_g_req = 1'b0;
        cfg_rise = -100; load_cyc = -100; ack_cyc = -100;
        p0 = 0; p1 = 0; pst = 0;
        drive(1'b1, 1'b1);
        for (int i = 0; i < n; i++) step();
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset with both requesters valid: nothing may be granted
        apply_reset(3);
        idle(2);

        // Single op 3*5 under the reset polynomial
        req0_valid = 1'b1; req1_valid = 1'b0;
        req0_a = 163'd3; req0_b = 176'd5;
        step();
        idle(LAT + 2);

        // Contention, then streaming from requester 0
        for (int i = 0; i < 4; i++) begin drive(1'b1, 1'b1); step(); end
        idle(LAT + 1);
        for (int i = 0; i < 10; i++) begin drive(1'b1, 1'b0); step(); end
        idle(LAT + 1);
        rand_traffic(30);

        // Reconfigure with ops in flight and requesters pushing, then use the new g
        for (int i = 0; i < 5; i++) begin drive(1'b1, 1'b1); step(); end
        run_cfg(rnd163(), 1'b1);
        rand_traffic(20);
        idle(LAT + 1);

        // Reload on an empty pipe with the unchanged polynomial
        run_cfg(g_m, 1'b0);
        idle(2);

        // Reset with six ops in flight: no result pulses afterwards
        for (int i = 0; i < 6; i++) begin drive(1'b1, 1'($urandom_range(0, 1))); step(); end
        apply_reset(2);
        idle(LAT + 3);

        rand_traffic(40);
        idle(LAT + 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gf163_mult_arbiter.md
# gf163_mult_arbiter

Shares one pipelined 16-bit digit-serial systolic GF(2^163) multiplier (`pipeline_16bit_top`) between two requesters. The block arbitrates round-robin with at most one issue per cycle, tags each operation with its requester, and returns each product to its owner. It also owns the field polynomial `g` and sequences safe reconfiguration of `g`: it stops issuing, drains the pipeline, loads the new value, then resumes. It sits between the crypto-engine requesters and the multiplier top.

## Interface
- `DATA_WIDTH`, 163, field element width (`a`, `g`, result).
- `B_WIDTH`, 176, digit-padded `b` width (11 digits × 16).
- `LATENCY`, 11, multiplier latency in cycles, sample to valid `t_i_j_out`.
- `G_RESET`, 163'hC9, reset value of the `g` register (low bits of x^163+x^7+x^6+x^3+1).
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous reset, active-low.
- `req0_valid`, `req1_valid`  in  1  operation request.
- `req0_ready`, `req1_ready`  out  1  grant; handshake fires on valid&ready at the clock edge.
- `req0_a`, `req1_a`  in  DATA_WIDTH  multiplicand.
- `req0_b`, `req1_b`  in  B_WIDTH  multiplier operand, top 13 bits zero.
- `res0_valid`, `res1_valid`  out  1  one-cycle result pulse. There is no backpressure.
- `res0_data`, `res1_data`  out  DATA_WIDTH  product; `mul_t` passed through.
- `cfg_g_req`  in  1  request a `g` reload; held high until ack.
- `cfg_g`  in  DATA_WIDTH  new polynomial; stable while `cfg_g_req` is high.
- `cfg_g_ack`  out  1  one-cycle pulse when the new `g` is in effect.
- `busy`  out  1  high when any operation is in flight or the state is not RUN.
- `mul_a`  out  DATA_WIDTH  to multiplier `a`.
- `mul_b`  out  B_WIDTH  to multiplier `b`.
- `mul_g`  out  DATA_WIDTH  to multiplier `g`.
- `mul_t`  in  DATA_WIDTH  from multiplier `t_i_j_out`.

## Operation
- **State machine:** RUN, DRAIN.
  - RUN → DRAIN when `cfg_g_req`=1.
  - DRAIN → RUN at the edge where in-flight count = 0. At that edge `g_reg` is loaded from `cfg_g`, and `cfg_g_ack` pulses in the following cycle.
- **Grant rules:**
  - Grants happen only in RUN with `cfg_g_req`=0. Otherwise both `ready` signals are 0.
  - One requester valid: that requester is granted.
  - Both valid: grant the requester not granted most recently. `last_grant` resets to 1, so req0 wins the first tie.
  - `ready` is combinational from `valid`, state, `cfg_g_req` and `last_grant`.
- **Multiplier drive:**
  - `mul_a`/`mul_b` carry the granted operands in the issue cycle and zero otherwise.
  - `mul_g` = `g_reg` at all times.
- **Tag pipe:** LATENCY stages of {valid, owner}, shifted every edge. Issue enters stage 0.
- **Result delivery:** `resk_valid` = stage-out valid & owner==k. Both `resk_data` = `mul_t` (a `data` value is meaningful only while its `valid` is high).
- **In-flight counter:** range 0..LATENCY. +1 on issue, −1 on retire, unchanged when both occur in the same cycle.
- **Boundary conditions:**
  - `cfg_g_req` rising in the same cycle as a request: the request is not granted.
  - `cfg_g_req` with the pipe empty: one DRAIN cycle, then load.
  - `cfg_g` equal to the current `g`: full drain/load sequence anyway.
  - `cfg_g_req` dropped before ack: illegal; behaviour undefined.
- **Reset:**
  - Clears the tag pipe and counter; in-flight results are discarded with no `res` pulse.
  - State = RUN, `g_reg` = G_RESET, `last_grant` = 1.
  - Output values in reset: all `ready`/`valid`/`ack` = 0, `busy` = 0, `mul_a`/`mul_b` = 0, `mul_g` = G_RESET.

## Timing
- Handshake in cycle c → `resk_valid` high in exactly cycle c+LATENCY (c+11 by default), with the product on `resk_data`.
- Throughput: one issue per cycle with no bubbles. Back-to-back issues produce back-to-back results in issue order.
- `g` reload cost: (remaining in-flight cycles) + 1 cycle; ack in the cycle after the load edge. The first issue under the new `g` is possible in the ack cycle.
- `busy` is registered-derived: high from the cycle after the first issue until the cycle the last result retires, and throughout DRAIN.

## Configuration
- `GF_ARB_PERF_EN` defined: adds outputs `perf_issue0` and `perf_issue1` (32-bit issue counters, saturating at 2^32−1) and `perf_stall` (32-bit, counts cycles where some `valid` is high and no grant occurs). All three reset to 0.
- Not defined: the ports and counters are absent, and there is no other behavioural difference.

## Test plan
- Single op: req0 a=3, b=5, g=0xC9, issued in cycle 0 → `res0_valid` in cycle 11, `res0_data`=0xF; `res1_valid` never high.
- Contention: req0 and req1 valid for 4 cycles → grants alternate 0,1,0,1; results alternate owners in cycles 11–14.
- Streaming: req0 issues 10 back-to-back ops → `res0_valid` high cycles 11–20 with products in issue order, checked against a software GF(2^163) model.
- Reconfig mid-stream: 5 ops in flight, raise `cfg_g_req` → both `ready`=0, all 5 results delivered with the old `g`, then ack. The next op uses the new `g`.
- Reset mid-op: assert `rst_n`=0 with 6 ops in flight → no `res` pulses; after release `mul_g`=0xC9, `busy`=0.
- PERF (macro on): 4-cycle contention followed by 1 DRAIN cycle with req0 valid → `perf_issue0`=2, `perf_issue1`=2, `perf_stall`=1.
